adf4351_prog_ctrl: RTL
======================

// Module: adf4351_prog_ctrl
// PURPOSE
//  Sequences one ADF4351 retune: requests R0/R4 from the frequency-calc block, then writes R5..R0 over the 3-wire bus (SCLK/SDATA/LE).
//  Sits between the host command decoder (FREQ/LO_SET/REQ) and the synthesizer pins; sole owner of the calc block's CFG_EN.
// PARAMETERS
//  CLK_DIV    2             CLK cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV
//  LE_CYCLES  4             CLK cycles LE is held high after each 32-bit word
//  GAP_CYCLES 4             CLK cycles of idle bus (LE low, SCLK low) between words
//  CALC_TMO   15            max CLK cycles waiting for CALC_DONE before error
//  R5_VAL     32'h00580005  fixed R5 word; R3_VAL 32'h000004B3; R2_VAL 32'h00004E42; R1_VAL 32'h08008011
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   asynchronous reset, active low
//  REQ        in   1   one-cycle retune request
//  FREQ       in   24  target frequency, kHz (sampled on REQ acceptance)
//  LO_SET     in   1   LO mode flag, passed to calc block
//  CALC_EN    out  1   one-cycle pulse to calc block CFG_EN
//  CALC_FREQ  out  24  registered FREQ to calc block
//  CALC_LO    out  1   registered LO_SET to calc block
//  CALC_DONE  in   1   calc block DONE pulse
//  CALC_R0    in   32  calc block R0 word
//  CALC_R4    in   32  calc block R4 word
//  SCLK       out  1   ADF4351 CLK pin
//  SDATA      out  1   ADF4351 DATA pin
//  LE         out  1   ADF4351 LE pin
//  BUSY       out  1   high from REQ acceptance until return to IDLE
//  DONE       out  1   one-cycle pulse: full sequence written successfully
//  ERR        out  1   sticky: calc timeout; cleared by next accepted REQ
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word index 0; pending flag 0.
//  States: IDLE -> CALC_REQ -> CALC_WAIT -> LOAD -> SHIFT -> LATCH -> GAP -> (LOAD | [LOCK_WAIT] | FIN) -> IDLE.
//  IDLE: REQ=1 -> register FREQ/LO_SET to CALC_FREQ/CALC_LO, clear ERR, BUSY=1, go CALC_REQ.
//  CALC_REQ: CALC_EN=1 for exactly one cycle; go CALC_WAIT; timeout counter cleared.
//  CALC_WAIT: on CALC_DONE capture CALC_R0/CALC_R4 same cycle, go LOAD; counter reaching CALC_TMO -> ERR=1, BUSY=0, IDLE, no bus activity.
//  LOAD: select word by index 0..5 = R5,R4(captured),R3,R2,R1,R0(captured); load 32-bit shift reg.
//  SHIFT: MSB first. SDATA updates while SCLK low; SCLK high CLK_DIV cycles, low CLK_DIV cycles; exactly 32 rising edges; SCLK ends low.
//  LATCH: SDATA=0, LE=1 for LE_CYCLES cycles, then LE=0.
//  GAP: GAP_CYCLES idle; index<5 -> index+1, LOAD; index==5 -> FIN (or LOCK_WAIT).
//  FIN: DONE=1 one cycle, BUSY=0, index=0, IDLE.
//  REQ while BUSY: set pending flag, FREQ not sampled; at return to IDLE a set pending flag starts a new sequence next cycle using FREQ present then. Multiple busy REQs collapse to one.
//  REQ in same cycle as FIN: treated as pending. Reset mid-frame: bus forced to SCLK=0/SDATA=0/LE=0 immediately; partial word is discarded by the device (no LE).
//  Word time = 64*CLK_DIV + LE_CYCLES + GAP_CYCLES + 1 (LOAD) cycles.
// CONFIGURATION
//  ADF_LOCK_WAIT_EN defined: extra input LOCK_DET (1 bit, async, 2-FF synchronised); after R0 GAP enter LOCK_WAIT;
//   DONE only after LOCK_DET high 8 consecutive cycles; 65535 cycles without lock -> ERR=1, no DONE, IDLE.
//  Undefined: no LOCK_DET port, no LOCK_WAIT state; DONE right after R0 GAP.
// TESTING
//  Reset then idle 100 cycles -> SCLK/SDATA/LE/BUSY/DONE/ERR all 0, CALC_EN never pulses.
//  CLK_DIV=2, REQ FREQ=24'd1000000, model calc DONE after 3 cycles R0=32'h00501F40 R4=32'h00AC803C -> bus decodes 6 words 00580005,00AC803C,000004B3,00004E42,08008011,00501F40; DONE once.
//  Check timing CLK_DIV=2: 32 SCLK rises/word, period 4 CLK, LE high exactly 4 cycles, LE never high while SCLK toggles.
//  Calc model never asserts DONE -> after 15 cycles ERR=1, BUSY=0, no SCLK edges; next REQ clears ERR.
//  REQ x3 during word 2 with FREQ changing -> exactly one extra sequence, using FREQ at IDLE return.
//  Assert RST during word 3 bit 10 -> outputs 0 same cycle; post-reset REQ yields complete clean 6-word sequence.

Source files
------------

// File: rtl/adf4351_prog_ctrl.sv
// ADF4351 retune sequencer: fetches R0/R4 from the frequency-calc block, then shifts R5..R0 out over SCLK/SDATA/LE.
// Optional lock wait after the final word is enabled with `define ADF_LOCK_WAIT_EN (adds lock_det_i).
module adf4351_prog_ctrl #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LE_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CALC_TMO   = 15,
  parameter logic [31:0] R5_VAL     = 32'h00580005,
  parameter logic [31:0] R3_VAL     = 32'h000004B3,
  parameter logic [31:0] R2_VAL     = 32'h00004E42,
  parameter logic [31:0] R1_VAL     = 32'h08008011
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [23:0] freq_i,
  input  logic        lo_set_i,
  output logic        calc_en_o,
  output logic [23:0] calc_freq_o,
  output logic        calc_lo_o,
  input  logic        calc_done_i,
  input  logic [31:0] calc_r0_i,
  input  logic [31:0] calc_r4_i,
`ifdef ADF_LOCK_WAIT_EN
  input  logic        lock_det_i,
`endif
  output logic        sclk_o,
  output logic        sdata_o,
  output logic        le_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
  localparam logic [15:0] PerLast = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] LeLast  = 16'(LE_CYCLES - 1);
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TmoLast = 16'(CALC_TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CALC_REQ, S_CALC_WAIT, S_LOAD, S_SHIFT, S_LATCH, S_GAP,
`ifdef ADF_LOCK_WAIT_EN
    S_LOCK_WAIT,
`endif
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] r0_q, r0_d, r4_q, r4_d;
  logic [23:0] freq_q, freq_d;
  logic        lo_q, lo_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic        sclk_q, sclk_d, sdata_q, sdata_d, le_q, le_d;
  logic [31:0] word;
`ifdef ADF_LOCK_WAIT_EN
  logic [1:0]  lock_sync_q;
  logic [2:0]  lock_cnt_q, lock_cnt_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      r0_q    <= '0;
      r4_q    <= '0;
      freq_q  <= '0;
      lo_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      r0_q    <= r0_d;
      r4_q    <= r4_d;
      freq_q  <= freq_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      le_q    <= le_d;
    end
  end

`ifdef ADF_LOCK_WAIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync_q <= '0;
      lock_cnt_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], lock_det_i};
      lock_cnt_q  <= lock_cnt_d;
    end
  end
`endif

  // Word order on the bus: R5, R4, R3, R2, R1, R0 (R0 last so its latch triggers the retune).
  always_comb begin
    word = r0_q;
    case (idx_q)
      3'd0:    word = R5_VAL;
      3'd1:    word = r4_q;
      3'd2:    word = R3_VAL;
      3'd3:    word = R2_VAL;
      3'd4:    word = R1_VAL;
      default: word = r0_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    r0_d    = r0_q;
    r4_d    = r4_q;
    freq_d  = freq_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    err_d   = err_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    le_d    = le_q;
`ifdef ADF_LOCK_WAIT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    if (req_i && state_q != S_IDLE) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_i || pend_q) begin
          freq_d  = freq_i;
          lo_d    = lo_set_i;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = S_CALC_REQ;
        end
      end
      S_CALC_REQ: begin
        cnt_d   = '0;
        state_d = S_CALC_WAIT;
      end
      S_CALC_WAIT: begin
        if (calc_done_i) begin
          r0_d    = calc_r0_i;
          r4_d    = calc_r4_i;
          state_d = S_LOAD;
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        shreg_d = word;
        sdata_d = word[31];
        sclk_d  = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      // Each bit: SCLK low for CLK_DIV cycles (data settles), then high for CLK_DIV cycles.
      S_SHIFT: begin
        if (cnt_q == PerLast) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd31) begin
            sdata_d = 1'b0;
            le_d    = 1'b1;
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[30:0], 1'b0};
            sdata_d = shreg_q[30];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == DivLast) sclk_d = 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == LeLast) begin
          le_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q < 3'd5) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end else begin
`ifdef ADF_LOCK_WAIT_EN
            lock_cnt_d = '0;
            state_d    = S_LOCK_WAIT;
`else
            state_d = S_FIN;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef ADF_LOCK_WAIT_EN
      // Lock must be seen on 8 consecutive synchronised samples; give up after 65535 cycles.
      S_LOCK_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (lock_sync_q[1]) lock_cnt_d = lock_cnt_q + 3'd1;
        else                lock_cnt_d = '0;
        if (lock_sync_q[1] && lock_cnt_q == 3'd7) begin
          state_d = S_FIN;
        end else if (cnt_q == 16'd65534) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
`endif
      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign calc_en_o   = (state_q == S_CALC_REQ);
  assign calc_freq_o = freq_q;
  assign calc_lo_o   = lo_q;
  assign sclk_o      = sclk_q;
  assign sdata_o     = sdata_q;
  assign le_o        = le_q;
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done_o      = (state_q == S_FIN);
  assign err_o       = err_q;

endmodule
